lbp_engine_p: RTL
=================

LBP_ENGINE_P -- requirements
Module: lbp_engine_p

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels; SHALL be at least 3.
REQ-002 Parameter IMG_H, default 8: image height in pixels; SHALL be at least 3.
REQ-003 Parameter AW, default 6: address width; SHALL equal ceil(log2(IMG_W*IMG_H)).
REQ-004 Parameter NONUNI_CODE, default 8'd5: output code for non-uniform patterns (see REQ-024).
REQ-005 clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 reset, input, 1: asynchronous, active-high reset.
REQ-007 gray_ready, input, 1: gray image available; starts a frame from IDLE.
REQ-008 gray_addr, output, AW: read address, equal to row*IMG_W+col.
REQ-009 gray_req, output, 1: read request, valid with gray_addr.
REQ-010 gray_data, input, 8: read data from the gray memory.
REQ-011 lbp_addr, output, AW: write address for the result.
REQ-012 lbp_write, output, 1: write strobe; the memory captures on the strobe's rising edge.
REQ-013 lbp_data, output, 8: LBP code to write.
REQ-014 finish, output, 1: frame complete.

Function
REQ-015 gray_data for an address driven with gray_req=1 after rising edge k SHALL be sampled at rising edge k+1.
REQ-016 States SHALL be IDLE, LOAD, SHIFT, CALC, WRITE and DONE.
REQ-017 IDLE->LOAD on gray_ready=1; gray_ready is ignored outside IDLE.
REQ-018 Scan order SHALL be raster over interior pixels only: rows 1..IMG_H-2, cols 1..IMG_W-2.
REQ-019 LOAD SHALL issue 9 reads (full 3x3 window) at the first interior column of each row.
REQ-020 SHIFT SHALL issue only 3 reads (new right column) for each later column, shifting the window left.
REQ-021 gray_req SHALL be 0 in IDLE, CALC, WRITE and DONE.
REQ-022 Neighbour bit = 1 iff neighbour >= centre (unsigned 8-bit compare).
REQ-023 Bit weights SHALL be: TL=bit0, T=bit1, TR=bit2, L=bit3, R=bit4, BL=bit5, B=bit6, BR=bit7.
REQ-024 A non-uniform pattern SHALL have more than 2 circular 0/1 transitions in the order TL,T,TR,R,BR,B,BL,L.
REQ-025 lbp_addr and lbp_data SHALL be registered and stable for the cycle before lbp_write rises and the cycle it is high.
REQ-026 lbp_write SHALL be a single-cycle pulse, with at least one low cycle between pulses.
REQ-027 Border addresses SHALL never be written.
REQ-028 Each frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) writes.
REQ-029 First write of a row SHALL start at most 14 cycles after the row's LOAD begins.
REQ-030 Each later write in a row SHALL start at most 6 cycles after the previous write.
REQ-031 After the last write, the block SHALL enter DONE and set finish=1 on the next cycle.
REQ-032 finish SHALL be held at 1 until reset; the block does not start another frame before reset.

Reset
REQ-033 reset=1 SHALL force IDLE immediately, including mid-frame.
REQ-034 reset=1 SHALL force gray_req, lbp_write and finish to 0, and gray_addr, lbp_addr and lbp_data to 0.
REQ-035 Window registers and counters SHALL clear on reset.
REQ-036 A frame interrupted by reset SHALL not resume; a new frame requires gray_ready in IDLE.

Configuration
REQ-037 Macro LBP_UNIFORM_EN defined: non-uniform codes SHALL be replaced by NONUNI_CODE; uniform codes pass unchanged.
REQ-038 LBP_UNIFORM_EN undefined: raw 8-bit codes SHALL be written, and no mapping logic SHALL be present.
REQ-039 Cycle timing SHALL be identical with and without LBP_UNIFORM_EN.

Verification
REQ-040 8x8 image, all pixels 0x10, gray_ready pulse -> 36 writes of 0xFF to interior addresses; border stays 0; finish=1.
REQ-041 8x8 ramp, pixel = col*16 -> every interior code is 0xD6.
REQ-042 8x8 checkerboard, pixel = ((r+c)&1)?0xFF:0x00 -> (r+c) even gives 0xFF; (r+c) odd gives 0xA5 without LBP_UNIFORM_EN, 0x05 with it.
REQ-043 IMG_W=16, IMG_H=4 with the ramp -> 28 writes, to addresses 17..30 and 33..46 only, all 0xD6.
REQ-044 reset asserted after the 10th write -> all outputs 0 within the same cycle; no writes until gray_ready; rerun matches REQ-041.
REQ-045 Protocol checker on REQ-041 -> lbp_write pulses single-cycle, addr/data stable as per REQ-025, gray_req low outside LOAD/SHIFT, finish within 270 cycles of gray_ready.

Source files
------------

// File: rtl/lbp_engine_p.sv
// Local binary pattern engine: raster scan of interior pixels with a sliding 3x3 window.
// Ports: clk, reset (async, high); gray_ready/gray_addr/gray_req/gray_data read side;
// lbp_addr/lbp_write/lbp_data write side; finish flags frame end.
// Macro LBP_UNIFORM_EN maps non-uniform patterns to NONUNI_CODE.
module lbp_engine_p #(
  parameter int         IMG_W       = 8,
  parameter int         IMG_H       = 8,
  parameter int         AW          = 6,
  parameter logic [7:0] NONUNI_CODE = 8'd5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic [AW-1:0] gray_addr,
  output logic          gray_req,
  input  logic [7:0]    gray_data,
  output logic [AW-1:0] lbp_addr,
  output logic          lbp_write,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, CALC, WRITE, DONE
  } state_t;

  localparam logic [AW-1:0] W_A    = AW'(IMG_W);
  localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 2);
  localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 2);

  state_t        state, nxt;
  logic [AW-1:0] row, col;
  logic [1:0]    cr, cc;
  logic [7:0]    win [0:2][0:2];

  logic          last_col, last_row;
  logic [AW-1:0] rd_r, rd_c;
  logic [7:0]    ctr, raw, code_out;

  assign last_col = (col == LAST_C);
  assign last_row = (row == LAST_R);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (gray_ready) nxt = LOAD;
      LOAD:  if (cr == 2'd2 && cc == 2'd2) nxt = CALC;
      SHIFT: if (cr == 2'd2) nxt = CALC;
      CALC:  nxt = WRITE;
      WRITE: begin
        if (!last_col)      nxt = SHIFT;
        else if (!last_row) nxt = LOAD;
        else                nxt = DONE;
      end
      DONE:  nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  // LOAD walks the full window; SHIFT fetches only the column right of the
  // window, whose centre col has already been advanced.
  always_comb begin
    rd_r = row + AW'(cr) - AW'(1);
    if (state == SHIFT) rd_c = col + AW'(1);
    else                rd_c = col + AW'(cc) - AW'(1);
    gray_req  = (state == LOAD) || (state == SHIFT);
    gray_addr = gray_req ? (rd_r * W_A + rd_c) : '0;
  end

  always_comb begin
    ctr = win[1][1];
    raw = {win[2][2] >= ctr, win[2][1] >= ctr,
           win[2][0] >= ctr, win[1][2] >= ctr,
           win[1][0] >= ctr, win[0][2] >= ctr,
           win[0][1] >= ctr, win[0][0] >= ctr};
  end

`ifdef LBP_UNIFORM_EN
  logic [7:0] ring, trans;
  // Ring is the clockwise neighbour order starting at top-left.
  always_comb begin
    ring  = {raw[3], raw[5], raw[6], raw[7],
             raw[4], raw[2], raw[1], raw[0]};
    trans = ring ^ {ring[6:0], ring[7]};
    if ($countones(trans) > 2) code_out = NONUNI_CODE;
    else                       code_out = raw;
  end
`else
  assign code_out = raw;
`endif

  // Result is latched in CALC so it is steady through WRITE; the strobe
  // then rises one cycle later, while the next fetch may already run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      cr        <= '0;
      cc        <= '0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      lbp_write <= 1'b0;
      finish    <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      lbp_write <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gray_ready) begin
            row <= AW'(1);
            col <= AW'(1);
            cr  <= '0;
            cc  <= '0;
          end
        end
        LOAD: begin
          win[cr][cc] <= gray_data;
          if (cc == 2'd2) begin
            cc <= '0;
            cr <= cr + 2'd1;
          end else begin
            cc <= cc + 2'd1;
          end
        end
        SHIFT: begin
          win[cr][2] <= gray_data;
          cr <= cr + 2'd1;
        end
        CALC: begin
          lbp_addr <= row * W_A + col;
          lbp_data <= code_out;
        end
        WRITE: begin
          lbp_write <= 1'b1;
          cr <= '0;
          cc <= '0;
          if (!last_col) begin
            col <= col + AW'(1);
            for (int r = 0; r < 3; r++) begin
              win[r][0] <= win[r][1];
              win[r][1] <= win[r][2];
            end
          end else if (!last_row) begin
            row <= row + AW'(1);
            col <= AW'(1);
          end
        end
        DONE: finish <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
